alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised, registered successor to the single-cycle datapath ALU. It adds signed/unsigned compare, XOR, arithmetic shift and signed overflow, plus an iterative multiply/divide unit with HI/LO registers behind a start/done handshake. It sits in the EX stage. The pipeline control stalls on `busy` and captures the result on `done`.

## Interface
- `WIDTH`, default 32: datapath width in bits (≥8, power of two).
- `SHAMT_W`, default 5: shift-amount width; must equal log2(WIDTH).
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request; sampled only when `busy`=0.
- `ALUOp`  in  4: operation select, sampled with `start`.
- `ALU_A`  in  WIDTH: operand A; shift amount is `ALU_A[SHAMT_W-1:0]`.
- `ALU_B`  in  WIDTH: operand B; shift source.
- `busy`  out  1: multi-cycle operation in progress.
- `done`  out  1: one-cycle pulse; result outputs valid.
- `ALU_Result`  out  WIDTH: registered result.
- `Zero`  out  1: `ALU_Result`==0, registered with the result.
- `carryout`  out  1: adder carry for ADD/SUB; 0 for all other ops.
- `overflow`  out  1: signed overflow for ADD/SUB; 0 for all other ops.
- `hi`, `lo`  out  WIDTH each: multiply/divide result registers.

## Operation
- Single-cycle ops (ALUOp):
  - 0 SLL: B<<sh.
  - 1 OR.
  - 2 SRL: B>>sh, logical.
  - 3 AND.
  - 4 ADD.
  - 5 NOR.
  - 6 SUB: A+~B+1.
  - 7 SRA: B>>>sh.
  - 8 SLT: signed A<B gives 1, else 0.
  - 9 SLTU: unsigned A<B.
  - 10 XOR.
  - 13 MFHI: result=`hi`.
  - 14 MFLO: result=`lo`.
  - 15 reserved: result 0.
- carryout is bit WIDTH of the WIDTH+1-bit add/sub. For SUB, carryout=1 means no borrow.
- overflow: operand signs equal (ADD) or different (SUB), and the result sign differs from A.
- Multi-cycle ops:
  - 11 MULTU: unsigned shift-add, one bit per cycle. {hi,lo} = A*B, 2·WIDTH bits, no truncation.
  - 12 DIVU: unsigned restoring division, one quotient bit per cycle. lo=A/B, hi=A%B.
  - ALU_Result = new `lo` on completion.
- Divide by zero: no special path; full latency. Result lo = all ones, hi = A.
- FSM states:
  - IDLE. `start` with a single-cycle op registers outputs and pulses `done`; state stays IDLE. `start` with op 11 goes to MUL; op 12 goes to DIV. Operands are latched internally.
  - MUL / DIV: iteration counter runs from WIDTH-1 down to 0. At 0 the FSM writes hi/lo/result, pulses `done`, and returns to IDLE.
- `start` while `busy`=1 is ignored; no queueing.
- hi/lo change only on MULTU/DIVU completion (and reset). Outputs hold between `done` pulses.
- Reset values: state IDLE, counter 0; `busy`, `done`, `ALU_Result`, `carryout`, `overflow`, `hi`, `lo` all 0; `Zero`=1.
- Reset mid-operation aborts it. No `done` is issued, and hi/lo return to 0.

## Timing
- Single-cycle op: `start` at edge N gives `done`=1 and valid outputs after edge N+1 (1-cycle latency). Back-to-back starts are accepted every cycle.
- MULTU/DIVU:
  - `start` at edge N raises `busy` after edge N+1.
  - `busy` stays high for WIDTH cycles.
  - `done` pulses and `busy` falls in the same cycle, WIDTH+1 cycles after `start`.
  - hi/lo update on that same edge.
- A new `start` can be accepted in the `done` cycle (`busy`=0).
- MFHI/MFLO issued on the `done` cycle see the updated hi/lo.

## Configuration
- `ALU_MDU_DIV_EN` defined: DIVU (op 12) is built as specified above.
- Undefined: no divider hardware is built. Op 12 acts as reserved: single-cycle, result 0, hi/lo unchanged, `busy` never asserted.

## Test plan
- Reset then idle: all outputs 0 and `Zero`=1; `start`=0 for 10 cycles keeps `done`=0.
- ADD A=0x7FFFFFFF, B=1 → result 0x80000000, overflow=1, carryout=0. SUB A=5, B=5 → result 0, Zero=1, carryout=1. SRA B=0x80000000, sh=4 → 0xF8000000. SLT A=-1, B=1 → 1. SLTU, same operands → 0.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → `done` exactly 33 cycles after start, hi=0xFFFFFFFE, lo=0x00000001. A `start` issued mid-operation is ignored.
- DIVU A=100, B=7 → lo=14, hi=2 after 33 cycles. DIVU B=0, A=9 → lo=0xFFFFFFFF, hi=9.
- `reset` asserted during MULTU cycle 10 → `busy`=0 next cycle, no `done`, hi=lo=0. A subsequent MFLO returns 0.
- Regression at WIDTH=16, SHAMT_W=4: MULTU 0xFFFF×2 gives hi=0x0001, lo=0xFFFE, latency 17. Without `ALU_MDU_DIV_EN`, op 12 returns 0 in 1 cycle.

Source files
------------

// File: rtl/alu_mdu.sv
// Registered EX-stage ALU with an iterative multiply/divide unit and HI/LO registers.
// Build option: define ALU_MDU_DIV_EN to include the restoring divider (DIVU, op 12).
module alu_mdu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         ALUOp,
  input  logic [WIDTH-1:0]   ALU_A,
  input  logic [WIDTH-1:0]   ALU_B,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   ALU_Result,
  output logic               Zero,
  output logic               carryout,
  output logic               overflow,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam logic [3:0] OP_SLL = 4'd0,  OP_OR   = 4'd1,  OP_SRL  = 4'd2,  OP_AND  = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4,  OP_NOR  = 4'd5,  OP_SUB  = 4'd6,  OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT = 4'd8,  OP_SLTU = 4'd9,  OP_XOR  = 4'd10, OP_MULTU = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12, OP_MFHI = 4'd13, OP_MFLO = 4'd14;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t               state_q, state_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;   // multiplicand or divisor
  logic [2*WIDTH-1:0]   acc_q, acc_d;     // {partial hi, partial lo} or {remainder, quotient}
  logic [WIDTH-1:0]     res_q, res_d, hi_q, hi_d, lo_q, lo_d;
  logic                 zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;

  logic [WIDTH-1:0]     alu_res;
  logic                 alu_cout, alu_ovf;
  logic [WIDTH:0]       add_full, sub_full;
  logic [SHAMT_W-1:0]   sh;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      zero_q  <= 1'b1;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      zero_q  <= zero_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && ALUOp == OP_MULTU) state_d = S_MUL;
`ifdef ALU_MDU_DIV_EN
        if (start && ALUOp == OP_DIVU)  state_d = S_DIV;
`endif
      end
      S_MUL, S_DIV: if (cnt_q == '0) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Single-cycle ALU
  always_comb begin
    sh       = ALU_A[SHAMT_W-1:0];
    add_full = {1'b0, ALU_A} + {1'b0, ALU_B};
    sub_full = {1'b0, ALU_A} + {1'b0, ~ALU_B} + {{WIDTH{1'b0}}, 1'b1};
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (ALUOp)
      OP_SLL:  alu_res = ALU_B << sh;
      OP_OR:   alu_res = ALU_A | ALU_B;
      OP_SRL:  alu_res = ALU_B >> sh;
      OP_AND:  alu_res = ALU_A & ALU_B;
      OP_ADD: begin
        alu_res  = add_full[WIDTH-1:0];
        alu_cout = add_full[WIDTH];
        alu_ovf  = (ALU_A[WIDTH-1] == ALU_B[WIDTH-1]) && (add_full[WIDTH-1] != ALU_A[WIDTH-1]);
      end
      OP_NOR:  alu_res = ~(ALU_A | ALU_B);
      OP_SUB: begin
        alu_res  = sub_full[WIDTH-1:0];
        alu_cout = sub_full[WIDTH];
        alu_ovf  = (ALU_A[WIDTH-1] != ALU_B[WIDTH-1]) && (sub_full[WIDTH-1] != ALU_A[WIDTH-1]);
      end
      OP_SRA:  alu_res = WIDTH'($signed(ALU_B) >>> sh);
      OP_SLT:  alu_res = WIDTH'($signed(ALU_A) < $signed(ALU_B));
      OP_SLTU: alu_res = WIDTH'(ALU_A < ALU_B);
      OP_XOR:  alu_res = ALU_A ^ ALU_B;
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // One shift-add multiply step: add multiplicand into the upper half, then shift right
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

`ifdef ALU_MDU_DIV_EN
  logic [WIDTH:0]       div_shift, div_rem;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;

  // One restoring-division step; a zero divisor always "fits", giving all-ones / A
  always_comb begin
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_rem   = div_ge ? (div_shift - {1'b0, opnd_q}) : div_shift;
    div_next  = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
  end
`endif

  always_comb begin
    busy   = (state_q != S_IDLE);
    cnt_d  = cnt_q;
    opnd_d = opnd_q;
    acc_d  = acc_q;
    res_d  = res_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    zero_d = zero_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (ALUOp == OP_MULTU) begin
            opnd_d = ALU_A;
            acc_d  = {{WIDTH{1'b0}}, ALU_B};
            cnt_d  = SHAMT_W'(WIDTH - 1);
`ifdef ALU_MDU_DIV_EN
          end else if (ALUOp == OP_DIVU) begin
            opnd_d = ALU_B;
            acc_d  = {{WIDTH{1'b0}}, ALU_A};
            cnt_d  = SHAMT_W'(WIDTH - 1);
`endif
          end else begin
            res_d  = alu_res;
            zero_d = (alu_res == '0);
            cout_d = alu_cout;
            ovf_d  = alu_ovf;
            done_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == '0) begin
          cnt_d  = '0;
          hi_d   = mul_next[2*WIDTH-1:WIDTH];
          lo_d   = mul_next[WIDTH-1:0];
          res_d  = mul_next[WIDTH-1:0];
          zero_d = (mul_next[WIDTH-1:0] == '0);
          cout_d = 1'b0;
          ovf_d  = 1'b0;
          done_d = 1'b1;
        end
      end
`ifdef ALU_MDU_DIV_EN
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == '0) begin
          cnt_d  = '0;
          hi_d   = div_next[2*WIDTH-1:WIDTH];
          lo_d   = div_next[WIDTH-1:0];
          res_d  = div_next[WIDTH-1:0];
          zero_d = (div_next[WIDTH-1:0] == '0);
          cout_d = 1'b0;
          ovf_d  = 1'b0;
          done_d = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  assign done       = done_q;
  assign ALU_Result = res_q;
  assign Zero       = zero_q;
  assign carryout   = cout_q;
  assign overflow   = ovf_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: 32-bit instance checked each cycle against an arithmetic model,
// plus a 16-bit instance exercised with directed vectors.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ALUOp;
  logic [31:0] ALU_A, ALU_B;
  logic        busy, done, Zero, carryout, overflow;
  logic [31:0] ALU_Result, hi, lo;

  logic        s16_start;
  logic [3:0]  s16_op;
  logic [15:0] s16_a, s16_b;
  logic        s16_busy, s16_done, s16_zero, s16_cout, s16_ovf;
  logic [15:0] s16_res, s16_hi, s16_lo;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUOp(ALUOp), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .busy(busy), .done(done), .ALU_Result(ALU_Result), .Zero(Zero),
    .carryout(carryout), .overflow(overflow), .hi(hi), .lo(lo));

  alu_mdu #(.WIDTH(16), .SHAMT_W(4)) dut16 (
    .clk(clk), .reset(reset), .start(s16_start), .ALUOp(s16_op), .ALU_A(s16_a), .ALU_B(s16_b),
    .busy(s16_busy), .done(s16_done), .ALU_Result(s16_res), .Zero(s16_zero),
    .carryout(s16_cout), .overflow(s16_ovf), .hi(s16_hi), .lo(s16_lo));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: results from plain arithmetic, timing as an edge countdown
  int          m_left = 0;
  logic        m_done = 1'b0, m_zero = 1'b1, m_c = 1'b0, m_o = 1'b0;
  logic [31:0] m_res = '0, m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic [63:0] prod;
  longint      sa, sb, ss;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (reset) begin
      m_left = 0; m_res = '0; m_zero = 1'b1; m_c = 1'b0; m_o = 1'b0; m_hi = '0; m_lo = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = p_hi; m_lo = p_lo; m_res = p_lo; m_zero = (p_lo == 0);
        m_c = 1'b0; m_o = 1'b0; m_done = 1'b1;
      end
    end else if (start) begin
      if (ALUOp == 4'd11) begin
        prod = 64'(ALU_A) * 64'(ALU_B);
        p_hi = prod[63:32]; p_lo = prod[31:0]; m_left = 32;
`ifdef ALU_MDU_DIV_EN
      end else if (ALUOp == 4'd12) begin
        if (ALU_B == 0) begin p_lo = 32'hFFFF_FFFF; p_hi = ALU_A; end
        else begin p_lo = ALU_A / ALU_B; p_hi = ALU_A % ALU_B; end
        m_left = 32;
`endif
      end else begin
        sa = longint'($signed(ALU_A));
        sb = longint'($signed(ALU_B));
        m_c = 1'b0; m_o = 1'b0;
        case (ALUOp)
          4'd0:  m_res = ALU_B << ALU_A[4:0];
          4'd1:  m_res = ALU_A | ALU_B;
          4'd2:  m_res = ALU_B >> ALU_A[4:0];
          4'd3:  m_res = ALU_A & ALU_B;
          4'd4: begin
            m_res = ALU_A + ALU_B;
            m_c = (64'(ALU_A) + 64'(ALU_B)) > 64'hFFFF_FFFF;
            ss = sa + sb;
            m_o = (ss > longint'(32'h7FFF_FFFF)) || (ss < -longint'(32'h8000_0000));
          end
          4'd5:  m_res = ~(ALU_A | ALU_B);
          4'd6: begin
            m_res = ALU_A - ALU_B;
            m_c = (ALU_A >= ALU_B);
            ss = sa - sb;
            m_o = (ss > longint'(32'h7FFF_FFFF)) || (ss < -longint'(32'h8000_0000));
          end
          4'd7:  m_res = 32'($signed(ALU_B) >>> ALU_A[4:0]);
          4'd8:  m_res = (sa < sb) ? 32'd1 : 32'd0;
          4'd9:  m_res = (ALU_A < ALU_B) ? 32'd1 : 32'd0;
          4'd10: m_res = ALU_A ^ ALU_B;
          4'd13: m_res = m_hi;
          4'd14: m_res = m_lo;
          default: m_res = '0;
        endcase
        m_zero = (m_res == 0);
        m_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc busy", 64'(busy), 64'(m_left > 0));
      chk("cyc done", 64'(done), 64'(m_done));
      chk("cyc result", 64'(ALU_Result), 64'(m_res));
      chk("cyc zero", 64'(Zero), 64'(m_zero));
      chk("cyc carry", 64'(carryout), 64'(m_c));
      chk("cyc ovf", 64'(overflow), 64'(m_o));
      chk("cyc hi", 64'(hi), 64'(m_hi));
      chk("cyc lo", 64'(lo), 64'(m_lo));
    end
  end

  // Issue one op (caller sits just after an edge), wait for done, pin result and latency
  task automatic run(input string name, input logic [3:0] op, input logic [31:0] a, b,
                     input logic [31:0] exp_res, input int exp_lat, input bit poke);
    int lat;
    lat = 0;
    start = 1'b1; ALUOp = op; ALU_A = a; ALU_B = b;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (k == 1 || k == 6) start = 1'b0;
      if (poke && k == 5) begin start = 1'b1; ALUOp = 4'd4; ALU_A = 32'd1; ALU_B = 32'd2; end
      if (done) begin lat = k; break; end
    end
    start = 1'b0;
    $display("[TB] %s op=%0d A=%h B=%h -> res=%h hi=%h lo=%h lat=%0d", name, op, a, b, ALU_Result, hi, lo, lat);
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    chk({name, " result"}, 64'(ALU_Result), 64'(exp_res));
  endtask

  task automatic run16(input string name, input logic [3:0] op, input logic [15:0] a, b,
                       output int lat, output bit saw_busy);
    lat = 0; saw_busy = 1'b0;
    s16_start = 1'b1; s16_op = op; s16_a = a; s16_b = b;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (k == 1) s16_start = 1'b0;
      if (s16_busy) saw_busy = 1'b1;
      if (s16_done) begin lat = k; break; end
    end
    s16_start = 1'b0;
    $display("[TB] %s op=%0d A=%h B=%h -> res=%h hi=%h lo=%h lat=%0d", name, op, a, b, s16_res, s16_hi, s16_lo, lat);
  endtask

  initial begin
    int  lat16;
    bit  b16;
    logic [31:0] hi_before, lo_before;
    reset = 1'b1; start = 1'b0; ALUOp = '0; ALU_A = '0; ALU_B = '0;
    s16_start = 1'b0; s16_op = '0; s16_a = '0; s16_b = '0;
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    chk("reset result", 64'(ALU_Result), 64'h0);
    chk("reset zero", 64'(Zero), 64'h1);
    chk("reset busy/done", 64'({busy, done, carryout, overflow}), 64'h0);
    chk("reset hi", 64'(hi), 64'h0);
    chk("reset lo", 64'(lo), 64'h0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle done", 64'(done), 64'h0);
    end

    run("ADD ovf", 4'd4, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, 0);
    chk("ADD ovf flag", 64'(overflow), 64'h1);
    chk("ADD carry", 64'(carryout), 64'h0);
    run("ADD wrap", 4'd4, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0);
    chk("ADD wrap carry/zero", 64'({carryout, Zero, overflow}), 64'b110);
    run("SUB eq", 4'd6, 32'd5, 32'd5, 32'h0, 1, 0);
    chk("SUB eq zero/carry", 64'({Zero, carryout, overflow}), 64'b110);
    run("SUB borrow", 4'd6, 32'd0, 32'd1, 32'hFFFF_FFFF, 1, 0);
    chk("SUB borrow carry", 64'(carryout), 64'h0);
    run("SUB ovf", 4'd6, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1, 0);
    chk("SUB ovf flags", 64'({carryout, overflow}), 64'b11);
    run("SRA", 4'd7, 32'd4, 32'h8000_0000, 32'hF800_0000, 1, 0);
    run("SLT", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 0);
    run("SLTU", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0);
    run("SLL", 4'd0, 32'd8, 32'h0000_0F0F, 32'h000F_0F00, 1, 0);
    run("SRL", 4'd2, 32'd4, 32'hF000_0000, 32'h0F00_0000, 1, 0);
    run("OR", 4'd1, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 1, 0);
    run("AND", 4'd3, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1, 0);
    run("NOR", 4'd5, 32'h0, 32'h0, 32'hFFFF_FFFF, 1, 0);
    run("XOR", 4'd10, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1, 0);
    run("RSVD", 4'd15, 32'h1234, 32'h5678, 32'h0, 1, 0);

    run("MULTU max", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 1);
    chk("MULTU hi", 64'(hi), 64'hFFFF_FFFE);
    chk("MULTU lo", 64'(lo), 64'h0000_0001);
    run("MFHI", 4'd13, 32'h0, 32'h0, 32'hFFFF_FFFE, 1, 0);
    run("MULTU mix", 4'd11, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 33, 0);
    chk("MULTU mix hi", 64'(hi), 64'h0000_0002);

`ifdef ALU_MDU_DIV_EN
    run("DIVU", 4'd12, 32'd100, 32'd7, 32'd14, 33, 0);
    chk("DIVU hi", 64'(hi), 64'd2);
    run("DIVU by0", 4'd12, 32'd9, 32'd0, 32'hFFFF_FFFF, 33, 0);
    chk("DIVU by0 hi", 64'(hi), 64'd9);
`else
    hi_before = hi; lo_before = lo;
    run("op12 rsvd", 4'd12, 32'd100, 32'd7, 32'h0, 1, 0);
    chk("op12 hi kept", 64'(hi), 64'(hi_before));
    chk("op12 lo kept", 64'(lo), 64'(lo_before));
`endif

    // Abort a multiply with reset partway through
    start = 1'b1; ALUOp = 4'd11; ALU_A = 32'h1234_5678; ALU_B = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("mid busy before reset", 64'(busy), 64'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("[TB] reset mid-MULTU -> busy=%0d done=%0d hi=%h lo=%h", busy, done, hi, lo);
    chk("abort busy", 64'(busy), 64'h0);
    chk("abort done", 64'(done), 64'h0);
    chk("abort hi/lo", {hi, lo}, 64'h0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("abort no done", 64'(done), 64'h0);
    end
    run("MFLO after abort", 4'd14, 32'h0, 32'h0, 32'h0, 1, 0);
    chk("MFLO zero flag", 64'(Zero), 64'h1);

    run16("W16 MULTU", 4'd11, 16'hFFFF, 16'h0002, lat16, b16);
    chk("W16 mul latency", 64'(lat16), 64'd17);
    chk("W16 mul hi", 64'(s16_hi), 64'h0001);
    chk("W16 mul lo", 64'(s16_lo), 64'hFFFE);
    chk("W16 mul result", 64'(s16_res), 64'hFFFE);
`ifdef ALU_MDU_DIV_EN
    run16("W16 DIVU", 4'd12, 16'd100, 16'd7, lat16, b16);
    chk("W16 div latency", 64'(lat16), 64'd17);
    chk("W16 div lo", 64'(s16_lo), 64'd14);
    chk("W16 div hi", 64'(s16_hi), 64'd2);
`else
    run16("W16 op12", 4'd12, 16'd100, 16'd7, lat16, b16);
    chk("W16 op12 latency", 64'(lat16), 64'd1);
    chk("W16 op12 result", 64'(s16_res), 64'h0);
    chk("W16 op12 no busy", 64'(b16), 64'h0);
    chk("W16 op12 hi/lo kept", 64'({s16_hi, s16_lo}), 64'h0001_FFFE);
`endif

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
